ttt_move_ctrl: RTL and testbench
================================

# ttt_move_ctrl

Sequential game controller that sits directly downstream of the row/column decoder. Each cycle it takes the decoder's 9-bit one-hot cell select plus a move strobe, checks the move is legal, and records it on the X/O board registers. It alternates turns, counts moves, and detects win or draw. Its outputs drive the board display and the status/LED logic.

## Interface
Parameters:
- none. Board size is fixed at 3x3; the win masks are package constants.

Ports:
- `clk` in 1: system clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `new_game` in 1: synchronous board clear; same effect as `rst`, but `rst` has priority.
- `pos` in 9: one-hot cell select from the decoder. Bit 0 = r1c1 … bit 8 = r3c3. All-zero means an invalid row/column code.
- `move_valid` in 1: player strobe, sampled only when `ready`=1.
- `ready` out 1: controller accepts a move this cycle.
- `board_x` out 9: cells owned by X.
- `board_o` out 9: cells owned by O.
- `turn` out 1: player to move; 0 = X, 1 = O.
- `illegal` out 1: one-cycle pulse when a rejected move is seen.
- `winner` out 2: 00 none, 01 X, 10 O, 11 draw.
- `win_mask` out 9: the winning line's cell mask; 0 when there is no win.
- `game_over` out 1: high while in DONE.
- `move_count` out 4: moves accepted, range 0..9.

## Operation
States:
- PLAY: `ready`=1.
- CHECK: `ready`=0; evaluates the updated board.
- DONE: `ready`=0; holds until `rst` or `new_game`.

A move is legal when all of the following hold:
- `pos` has exactly one bit set;
- `pos & (board_x | board_o)` == 0;
- the state is PLAY.

Legal move in PLAY:
- OR `pos` into `board_x` (if `turn`=0) or `board_o` (if `turn`=1).
- Increment `move_count`.
- Go to CHECK.

Illegal move (`move_valid`=1 in PLAY with zero, multi-hot, or occupied `pos`):
- Pulse `illegal`.
- Board, `turn` and count are unchanged; stay in PLAY.

`move_valid` in CHECK or DONE is ignored silently; no `illegal` pulse.

CHECK evaluates the player who just moved:
- If any of the 8 win masks is fully covered by that player's board: set `winner` (01 or 10), set `win_mask` to the lowest-indexed matching mask, go to DONE.
- Else if `move_count`==9: `winner`=11, `win_mask`=0, go to DONE.
- Else: toggle `turn`, return to PLAY.

When the ninth move completes a line, the win takes precedence over draw.

Reset / `new_game`:
- `board_x`=`board_o`=0, `turn`=0, `illegal`=0, `winner`=00, `win_mask`=0, `move_count`=0.
- State goes to PLAY, so `ready`=1 and `game_over`=0.
- Either one takes effect from any state, including mid-CHECK.
- If `new_game` and `move_valid` arrive together, the move is dropped.

## Timing
- `move_valid` sampled at edge N, legal: board and count update at N+1; state=CHECK and `ready`=0 during N+1.
- Result registered at N+2: `winner`, `win_mask` and `game_over`, or the toggled `turn` with `ready`=1.
- Throughput is one move per 2 cycles at most.
- Illegal move at N: `illegal`=1 for exactly the cycle after N; `ready` stays 1.
- Every output is registered. There is no combinational path from inputs to outputs.
- `move_count` never exceeds 9; DONE is entered at or before 9.

## Structure
Shared package `ttt_pkg` holds:
- state enum (PLAY, CHECK, DONE);
- winner codes (NONE, X, O, DRAW);
- the 8 win masks in index order:
  - rows: 0x007, 0x038, 0x1C0;
  - columns: 0x049, 0x092, 0x124;
  - diagonals: 0x111, 0x054.

One combinational sub-module, `ttt_line_check`:
- inputs: a 9-bit board;
- outputs: `hit` and the 9-bit `mask` of the lowest-indexed covered line.

## Test plan
- Reset, then release: all outputs at their reset values, `ready`=1. `pos`=0x001 strobe → `board_x`=0x001 at N+1, `turn`=1 at N+2.
- X wins: moves 0x001(X), 0x008(O), 0x002(X), 0x010(O), 0x004(X) → two cycles after the fifth strobe: `winner`=01, `win_mask`=0x007, `move_count`=5, `game_over`=1.
- Draw: moves 0x001, 0x002, 0x004, 0x010, 0x008, 0x020, 0x080, 0x040, 0x100 → `board_x`=0x18D, `board_o`=0x072, `winner`=11, `move_count`=9.
- Illegal moves: `pos`=0x000, then 0x003, then an occupied cell → one `illegal` pulse per strobe; board and `turn` unchanged.
- Ignored moves: strobe during CHECK, and strobe after `game_over` → no state change and no `illegal` pulse.
- `new_game` with simultaneous `move_valid` mid-game, and `rst` asserted during CHECK → next cycle all cleared, `ready`=1, `turn`=0.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared constants for the tic-tac-toe controller: FSM states, winner codes,
// the eight win lines and a one-hot helper.
package ttt_pkg;

   localparam logic [1:0] ST_PLAY  = 2'd0;
   localparam logic [1:0] ST_CHECK = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_X    = 2'b01;
   localparam logic [1:0] WIN_O    = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   localparam int unsigned NUM_LINES = 8;

   // Rows, then columns, then diagonals; index order sets win_mask priority.
   localparam logic [8:0] WIN_MASKS [0:NUM_LINES-1] = '{
      9'h007, 9'h038, 9'h1C0,
      9'h049, 9'h092, 9'h124,
      9'h111, 9'h054
   };

   function automatic logic is_one_hot(input logic [8:0] v);
      return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
   endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational line detector: reports whether a board covers any win line
// and returns the lowest-indexed covered line.
module ttt_line_check
   import ttt_pkg::*;
(
   input  logic [8:0] board,
   output logic       hit,
   output logic [8:0] mask
);

   // Scan from the highest index down so the lowest matching line wins.
   always_comb begin
      hit  = 1'b0;
      mask = 9'd0;
      for (int i = NUM_LINES - 1; i >= 0; i--) begin
         if ((board & WIN_MASKS[i]) == WIN_MASKS[i]) begin
            hit  = 1'b1;
            mask = WIN_MASKS[i];
         end else begin
            hit  = hit;
            mask = mask;
         end
      end
   end

endmodule

// File: rtl/ttt_move_ctrl.sv
// Tic-tac-toe move controller: validates one-hot moves, records them on the
// X/O boards, alternates turns and detects win or draw. All outputs registered.
module ttt_move_ctrl
   import ttt_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       new_game,
   input  logic [8:0] pos,
   input  logic       move_valid,
   output logic       ready,
   output logic [8:0] board_x,
   output logic [8:0] board_o,
   output logic       turn,
   output logic       illegal,
   output logic [1:0] winner,
   output logic [8:0] win_mask,
   output logic       game_over,
   output logic [3:0] move_count
);

   logic [1:0] state_r;
   logic       ready_r;
   logic [8:0] board_x_r;
   logic [8:0] board_o_r;
   logic       turn_r;
   logic       illegal_r;
   logic [1:0] winner_r;
   logic [8:0] win_mask_r;
   logic       game_over_r;
   logic [3:0] move_count_r;

   logic [8:0] mover_board_s;
   logic       line_hit_s;
   logic [8:0] line_mask_s;
   logic       legal_s;

   // In CHECK the turn has not toggled yet, so turn_r selects the mover.
   always_comb begin
      mover_board_s = turn_r ? board_o_r : board_x_r;
      legal_s       = is_one_hot(pos) && ((pos & (board_x_r | board_o_r)) == 9'd0);
   end

   ttt_line_check u_line_check (
      .board (mover_board_s),
      .hit   (line_hit_s),
      .mask  (line_mask_s)
   );

   // Game FSM and board registers; rst and new_game clear everything.
   always_ff @(posedge clk) begin
      if (rst || new_game) begin
         state_r      <= ST_PLAY;
         ready_r      <= 1'b1;
         board_x_r    <= 9'd0;
         board_o_r    <= 9'd0;
         turn_r       <= 1'b0;
         illegal_r    <= 1'b0;
         winner_r     <= WIN_NONE;
         win_mask_r   <= 9'd0;
         game_over_r  <= 1'b0;
         move_count_r <= 4'd0;
      end else begin
         illegal_r <= 1'b0;
         case (state_r)
            ST_PLAY: begin
               if (move_valid) begin
                  if (legal_s) begin
                     if (turn_r) begin
                        board_o_r <= board_o_r | pos;
                     end else begin
                        board_x_r <= board_x_r | pos;
                     end
                     move_count_r <= move_count_r + 4'd1;
                     state_r      <= ST_CHECK;
                     ready_r      <= 1'b0;
                  end else begin
                     illegal_r <= 1'b1;
                  end
               end
            end
            ST_CHECK: begin
               // A line on the ninth move outranks the draw.
               if (line_hit_s) begin
                  winner_r    <= turn_r ? WIN_O : WIN_X;
                  win_mask_r  <= line_mask_s;
                  state_r     <= ST_DONE;
                  game_over_r <= 1'b1;
               end else if (move_count_r == 4'd9) begin
                  winner_r    <= WIN_DRAW;
                  win_mask_r  <= 9'd0;
                  state_r     <= ST_DONE;
                  game_over_r <= 1'b1;
               end else begin
                  turn_r  <= ~turn_r;
                  state_r <= ST_PLAY;
                  ready_r <= 1'b1;
               end
            end
            ST_DONE: begin
               state_r <= ST_DONE;
            end
            default: begin
               state_r     <= ST_PLAY;
               ready_r     <= 1'b1;
               game_over_r <= 1'b0;
            end
         endcase
      end
   end

   assign ready      = ready_r;
   assign board_x    = board_x_r;
   assign board_o    = board_o_r;
   assign turn       = turn_r;
   assign illegal    = illegal_r;
   assign winner     = winner_r;
   assign win_mask   = win_mask_r;
   assign game_over  = game_over_r;
   assign move_count = move_count_r;

endmodule

// File: tb/tb_ttt_move_ctrl.sv
// Scoreboard bench for ttt_move_ctrl: stimulus pushes cycle-stamped expected
// snapshots, a negedge monitor pops and compares them.
module tb_ttt_move_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       new_game;
   logic [8:0] pos;
   logic       move_valid;
   logic       ready;
   logic [8:0] board_x;
   logic [8:0] board_o;
   logic       turn;
   logic       illegal;
   logic [1:0] winner;
   logic [8:0] win_mask;
   logic       game_over;
   logic [3:0] move_count;

   ttt_move_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .new_game   (new_game),
      .pos        (pos),
      .move_valid (move_valid),
      .ready      (ready),
      .board_x    (board_x),
      .board_o    (board_o),
      .turn       (turn),
      .illegal    (illegal),
      .winner     (winner),
      .win_mask   (win_mask),
      .game_over  (game_over),
      .move_count (move_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          at;
      string       nm;
      logic [36:0] v;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;

   // expected game state, updated by hand-driven tasks below
   logic [8:0] ex_bx, ex_bo, ex_wm;
   logic       ex_turn, ex_go;
   logic [1:0] ex_win;
   logic [3:0] ex_cnt;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [36:0] pack(input logic rdy, input logic [8:0] bx, input logic [8:0] bo,
                                        input logic trn, input logic ill, input logic [1:0] win,
                                        input logic [8:0] wm, input logic go, input logic [3:0] cnt);
      return {rdy, bx, bo, trn, ill, win, wm, go, cnt};
   endfunction

   // monitor: compare every snapshot due this cycle
   always @(negedge clk) begin
      logic [36:0] act;
      exp_t        e;
      act = pack(ready, board_x, board_o, turn, illegal, winner, win_mask, game_over, move_count);
      while (q.size() > 0 && q[0].at <= cyc) begin
         e = q.pop_front();
         n_vec = n_vec + 1;
         if (e.at != cyc || act !== e.v) begin
            n_bad = n_bad + 1;
            $display("FAIL %s @%0d: got rdy=%b x=%h o=%h t=%b ill=%b win=%b wm=%h go=%b cnt=%0d, want rdy=%b x=%h o=%h t=%b ill=%b win=%b wm=%h go=%b cnt=%0d (due %0d)",
                     e.nm, cyc, act[36], act[35:27], act[26:18], act[17], act[16], act[15:14], act[13:5], act[4], act[3:0],
                     e.v[36], e.v[35:27], e.v[26:18], e.v[17], e.v[16], e.v[15:14], e.v[13:5], e.v[4], e.v[3:0], e.at);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int at, input string nm, input logic [36:0] v);
      exp_t e;
      e.at = at;
      e.nm = nm;
      e.v  = v;
      q.push_back(e);
   endtask

   task automatic push_model(input int at, input string nm, input logic ill);
      push(at, nm, pack(!ex_go, ex_bx, ex_bo, ex_turn, ill, ex_win, ex_wm, ex_go, ex_cnt));
   endtask

   task automatic clear_model();
      ex_bx = 9'd0; ex_bo = 9'd0; ex_wm = 9'd0;
      ex_turn = 1'b0; ex_go = 1'b0; ex_win = 2'b00; ex_cnt = 4'd0;
   endtask

   // one legal move: board/count update next cycle, result the cycle after
   task automatic legal_move(input logic [8:0] p, input string nm, input logic [1:0] win, input logic [8:0] wm);
      move_valid = 1'b1; pos = p;
      step();
      move_valid = 1'b0; pos = 9'd0;
      if (ex_turn) ex_bo = ex_bo | p;
      else         ex_bx = ex_bx | p;
      ex_cnt = ex_cnt + 4'd1;
      push(cyc, {nm, "_upd"}, pack(1'b0, ex_bx, ex_bo, ex_turn, 1'b0, 2'b00, 9'd0, 1'b0, ex_cnt));
      ex_win = win; ex_wm = wm; ex_go = (win != 2'b00);
      if (!ex_go) ex_turn = ~ex_turn;
      push_model(cyc + 1, {nm, "_res"}, 1'b0);
      step();
   endtask

   task automatic rejected_move(input logic [8:0] p, input string nm, input logic ill);
      move_valid = 1'b1; pos = p;
      step();
      move_valid = 1'b0; pos = 9'd0;
      push_model(cyc, nm, ill);
      step();
      push_model(cyc, {nm, "_after"}, 1'b0);
   endtask

   task automatic do_new_game(input string nm);
      new_game = 1'b1;
      step();
      new_game = 1'b0;
      clear_model();
      push_model(cyc, nm, 1'b0);
   endtask

   initial begin
      rst = 1'b1; new_game = 1'b0; move_valid = 1'b0; pos = 9'd0;
      clear_model();
      step(); step();
      push(cyc, "reset", pack(1'b1, 9'd0, 9'd0, 1'b0, 1'b0, 2'b00, 9'd0, 1'b0, 4'd0));
      rst = 1'b0;
      step();
      push(cyc, "post_reset", pack(1'b1, 9'd0, 9'd0, 1'b0, 1'b0, 2'b00, 9'd0, 1'b0, 4'd0));
      if (ready !== 1'b1 || turn !== 1'b0 || move_count !== 4'd0) begin
         n_bad = n_bad + 1;
         $display("FAIL direct post_reset: rdy=%b t=%b cnt=%0d", ready, turn, move_count);
      end

      // X wins on the top row
      legal_move(9'h001, "xw1", 2'b00, 9'd0);
      legal_move(9'h008, "xw2", 2'b00, 9'd0);
      legal_move(9'h002, "xw3", 2'b00, 9'd0);
      legal_move(9'h010, "xw4", 2'b00, 9'd0);
      legal_move(9'h004, "xw5", 2'b01, 9'h007);
      push(cyc, "xwin_final", pack(1'b0, 9'h007, 9'h018, 1'b0, 1'b0, 2'b01, 9'h007, 1'b1, 4'd5));
      if (winner !== 2'b01 || win_mask !== 9'h007 || game_over !== 1'b1 || move_count !== 4'd5) begin
         n_bad = n_bad + 1;
         $display("FAIL direct xwin: win=%b wm=%h go=%b cnt=%0d", winner, win_mask, game_over, move_count);
      end
      rejected_move(9'h100, "ign_done", 1'b0);

      // full-board draw
      do_new_game("ng_clear1");
      legal_move(9'h001, "dr1", 2'b00, 9'd0);
      legal_move(9'h002, "dr2", 2'b00, 9'd0);
      legal_move(9'h004, "dr3", 2'b00, 9'd0);
      legal_move(9'h010, "dr4", 2'b00, 9'd0);
      legal_move(9'h008, "dr5", 2'b00, 9'd0);
      legal_move(9'h020, "dr6", 2'b00, 9'd0);
      legal_move(9'h080, "dr7", 2'b00, 9'd0);
      legal_move(9'h040, "dr8", 2'b00, 9'd0);
      legal_move(9'h100, "dr9", 2'b11, 9'd0);
      push(cyc, "draw_final", pack(1'b0, 9'h18D, 9'h072, 1'b0, 1'b0, 2'b11, 9'h000, 1'b1, 4'd9));
      if (board_x !== 9'h18D || board_o !== 9'h072 || winner !== 2'b11 || move_count !== 4'd9) begin
         n_bad = n_bad + 1;
         $display("FAIL direct draw: x=%h o=%h win=%b cnt=%0d", board_x, board_o, winner, move_count);
      end

      // ninth move completes the anti-diagonal: win beats draw
      do_new_game("ng_clear2");
      legal_move(9'h001, "w9_1", 2'b00, 9'd0);
      legal_move(9'h002, "w9_2", 2'b00, 9'd0);
      legal_move(9'h004, "w9_3", 2'b00, 9'd0);
      legal_move(9'h008, "w9_4", 2'b00, 9'd0);
      legal_move(9'h010, "w9_5", 2'b00, 9'd0);
      legal_move(9'h080, "w9_6", 2'b00, 9'd0);
      legal_move(9'h020, "w9_7", 2'b00, 9'd0);
      legal_move(9'h100, "w9_8", 2'b00, 9'd0);
      legal_move(9'h040, "w9_9", 2'b01, 9'h054);

      // illegal strobes: zero, multi-hot, occupied
      do_new_game("ng_clear3");
      legal_move(9'h001, "il_x", 2'b00, 9'd0);
      rejected_move(9'h000, "ill_zero", 1'b1);
      rejected_move(9'h003, "ill_multi", 1'b1);
      rejected_move(9'h001, "ill_occ", 1'b1);

      // strobe held into CHECK is ignored
      move_valid = 1'b1; pos = 9'h010;
      step();
      pos = 9'h020;
      ex_bo = ex_bo | 9'h010; ex_cnt = ex_cnt + 4'd1;
      push(cyc, "chk_upd", pack(1'b0, ex_bx, ex_bo, ex_turn, 1'b0, 2'b00, 9'd0, 1'b0, ex_cnt));
      step();
      move_valid = 1'b0; pos = 9'd0;
      ex_turn = ~ex_turn;
      push_model(cyc, "chk_ignored", 1'b0);
      step();
      push_model(cyc, "chk_after", 1'b0);

      // new_game together with a move mid-game drops the move
      move_valid = 1'b1; pos = 9'h002; new_game = 1'b1;
      step();
      move_valid = 1'b0; pos = 9'd0; new_game = 1'b0;
      clear_model();
      push_model(cyc, "ng_with_move", 1'b0);
      step();
      push_model(cyc, "ng_with_move2", 1'b0);

      // rst during CHECK
      move_valid = 1'b1; pos = 9'h001;
      step();
      move_valid = 1'b0; pos = 9'd0; rst = 1'b1;
      push(cyc, "pre_rst_check", pack(1'b0, 9'h001, 9'h000, 1'b0, 1'b0, 2'b00, 9'd0, 1'b0, 4'd1));
      step();
      rst = 1'b0;
      push(cyc, "rst_in_check", pack(1'b1, 9'd0, 9'd0, 1'b0, 1'b0, 2'b00, 9'd0, 1'b0, 4'd0));
      step();
      push(cyc, "rst_after", pack(1'b1, 9'd0, 9'd0, 1'b0, 1'b0, 2'b00, 9'd0, 1'b0, 4'd0));
      if (ready !== 1'b1 || turn !== 1'b0 || board_x !== 9'd0 || board_o !== 9'd0) begin
         n_bad = n_bad + 1;
         $display("FAIL direct rst_after: rdy=%b t=%b x=%h o=%h", ready, turn, board_x, board_o);
      end

      for (int k = 0; k < 20; k++) begin
         if (q.size() == 0) break;
         step();
      end
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         n_vec = n_vec + 1;
         n_bad = n_bad + 1;
         $display("FAIL %s: never compared, due %0d, now %0d", e.nm, e.at, cyc);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      if (n_bad == 0) begin
         $display("PASS");
      end else begin
         $display("FAIL");
      end
      $finish;
   end

endmodule
